// File: rtl/game_pkg.sv
// Shared types and constants for the scrambled-number sum game blocks.
package game_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_RST = '0;

endpackage : game_pkg

// File: rtl/edge_rise.sv
// Rising-edge detector: one-cycle pulse when d goes 0 -> 1 between clk edges.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Previous-sample register; reset to 1 so a level already high at release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b1;
    else     d_q <= d;
  end

  // Unknown d makes rise unknown, which the consumer's if() treats as no edge.
  assign rise = d & ~d_q;

endmodule : edge_rise

// File: rtl/counter.sv
// Event tally: increments once per rising edge of pulse, wrapping modulo 2**WIDTH.
module counter
  import game_pkg::*;
#(
  parameter int unsigned       WIDTH   = CNT_W,
  parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(CNT_RST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  output logic [WIDTH-1:0] count
);

  logic rise;

  edge_rise u_edge_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (pulse),
    .rise (rise)
  );

  // Tally register; natural overflow of the adder gives the silent wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= RST_VAL;
    else if (rise) count <= count + WIDTH'(1);
  end

endmodule : counter

// File: tb/tb_counter.sv
// Directed bench for counter: timed reset/press sequence, then a vector table.
module tb_counter;

  logic       clk;
  logic       rst;
  logic       pulse;
  logic [3:0] count;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       rst;
    logic       pulse;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  counter #(
    .WIDTH   (4),
    .RST_VAL (4'd0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pulse (pulse),
    .count (count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [3:0] exp);
    tests_run++;
    if (count !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: count=%0d expected %0d", name, $time, count, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    pulse = 1'b0;

    // 1. pulse held high across reset must not count
    #3  rst = 1'b1; pulse = 1'b1;
    #2  check("reset_value", 4'd0);                 // t=5
    #98 rst = 1'b0;                                 // t=103
    #8  check("held_after_release_a", 4'd0);        // t=111
    #20 check("held_after_release_b", 4'd0);        // t=131
    #20 check("held_after_release_c", 4'd0);        // t=151

    // 2. single press
    #12 pulse = 1'b0;                               // t=163
    #8  check("idle_low", 4'd0);                    // t=171
    #12 pulse = 1'b1;                               // t=183
    #8  check("single_press", 4'd1);                // t=191
    #20 check("press_held", 4'd1);                  // t=211

    // 3. asynchronous reset between edges
    #12 rst = 1'b1;                                 // t=223
    #1  check("async_reset_immediate", 4'd0);       // t=224
    #27 check("async_reset_across_edge", 4'd0);     // t=251
    #12 rst = 1'b0;                                 // t=263
    #8  check("after_reset_held_pulse", 4'd0);      // t=271
    #2;                                             // t=273, 3 ns after edge

    // 4. wrap: 16 separate presses, count 1..15 then 0
    for (int unsigned i = 1; i <= 16; i++) begin
      vecs.push_back('{rst: 1'b0, pulse: 1'b0, exp: 4'((i - 1) % 16)});
      vecs.push_back('{rst: 1'b0, pulse: 1'b1, exp: 4'(i % 16)});
    end
    vecs.push_back('{rst: 1'b0, pulse: 1'b1, exp: 4'd0});
    vecs.push_back('{rst: 1'b0, pulse: 1'b1, exp: 4'd0});

    // 5. toggle every cycle for 8 cycles: +1 every second cycle
    vecs.push_back('{rst: 1'b0, pulse: 1'b0, exp: 4'd0});
    vecs.push_back('{rst: 1'b0, pulse: 1'b1, exp: 4'd1});
    vecs.push_back('{rst: 1'b0, pulse: 1'b0, exp: 4'd1});
    vecs.push_back('{rst: 1'b0, pulse: 1'b1, exp: 4'd2});
    vecs.push_back('{rst: 1'b0, pulse: 1'b0, exp: 4'd2});
    vecs.push_back('{rst: 1'b0, pulse: 1'b1, exp: 4'd3});
    vecs.push_back('{rst: 1'b0, pulse: 1'b0, exp: 4'd3});
    vecs.push_back('{rst: 1'b0, pulse: 1'b1, exp: 4'd4});

    // reset coinciding with a rise wins; held pulse after release does not count
    vecs.push_back('{rst: 1'b0, pulse: 1'b0, exp: 4'd4});
    vecs.push_back('{rst: 1'b1, pulse: 1'b1, exp: 4'd0});
    vecs.push_back('{rst: 1'b0, pulse: 1'b1, exp: 4'd0});

    // rise right after release counts once a 0 has been sampled
    vecs.push_back('{rst: 1'b1, pulse: 1'b0, exp: 4'd0});
    vecs.push_back('{rst: 1'b0, pulse: 1'b0, exp: 4'd0});
    vecs.push_back('{rst: 1'b0, pulse: 1'b1, exp: 4'd1});
    vecs.push_back('{rst: 1'b0, pulse: 1'b1, exp: 4'd1});

    foreach (vecs[i]) begin
      rst   = vecs[i].rst;
      pulse = vecs[i].pulse;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].exp);
      #2;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_counter
